// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and mult_div_unit.
interface mult_div_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] opA;
    logic [DATA_WIDTH-1:0] opB;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, opA, opB,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on magnitudes,
// sign fix-up and HI/LO commit in a final cycle.
module mult_div_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mult_div_unit_if.slave bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*W-1:0] acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [W-1:0]   m_q, m_d;
    logic [1:0]     op_q, op_d;
    logic           sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

    logic           sign_a, sign_b;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     sum, shifted;
    logic           ge;
    logic [W-1:0]   rem_next, quo_fix, rem_fix;
    logic [2*W-1:0] prod_fix;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state, iteration step and commit logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        // Operand magnitudes; sign bits only count for the signed ops.
        sign_a = bus.op[0] & bus.opA[W-1];
        sign_b = bus.op[0] & bus.opB[W-1];
        abs_a  = sign_a ? -bus.opA : bus.opA;
        abs_b  = sign_b ? -bus.opB : bus.opB;

        // Shift-add step: conditionally add multiplicand, shift right one.
        sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? m_q : '0)};

        // Restoring step: shift in next dividend bit, subtract if it fits.
        shifted  = {acc_q[2*W-1:W], acc_q[W-1]};
        ge       = (shifted >= {1'b0, m_q});
        rem_next = ge ? W'(shifted - {1'b0, m_q}) : shifted[W-1:0];

        // Sign correction applied in FIX.
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = sa_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = bus.op;
                    sa_d    = sign_a;
                    sb_d    = sign_b;
                    if (bus.op[1]) begin
                        m_d   = abs_b;
                        acc_d = {{W{1'b0}}, abs_a};
                    end else begin
                        m_d   = abs_a;
                        acc_d = {{W{1'b0}}, abs_b};
                    end
                end
            end
            CALC: begin
                if (op_q[1]) begin
                    acc_d = {rem_next, acc_q[W-2:0], ge};
                end else begin
                    acc_d = {sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_q[1]) begin
                    // Divide by zero leaves remainder == |opA|, so rem_fix restores opA.
                    hi_d  = rem_fix;
                    lo_d  = (m_q == '0) ? '1 : quo_fix;
                    dbz_d = (m_q == '0);
                end else begin
                    hi_d  = prod_fix[2*W-1:W];
                    lo_d  = prod_fix[W-1:0];
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } res_t;

    typedef struct {
        res_t        r;
        int unsigned due;
        string       name;
    } entry_t;

    logic clk;
    logic rst;
    int unsigned cyc;
    int n_vec;
    int n_err;
    int done_seen;
    logic prev_done;
    entry_t sb[$];

    mult_div_unit_if #(.DATA_WIDTH(W)) bus ();

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp start and done.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model from the architectural definition of each op.
    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   r;
        longint sa;
        longint sb_v;
        longint p;
        logic [63:0] pu;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        r.dbz = 1'b0;
        case (op)
            2'b00: begin
                pu   = {32'b0, a} * {32'b0, b};
                r.hi = pu[63:32];
                r.lo = pu[31:0];
            end
            2'b01: begin
                p    = sa * sb_v;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    r.hi  = a;
                    r.lo  = '1;
                    r.dbz = 1'b1;
                end else if (op == 2'b10) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else begin
                    p    = sa / sb_v;
                    r.lo = p[31:0];
                    p    = sa % sb_v;
                    r.hi = p[31:0];
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            4: return -W'($urandom_range(1, 20));
            default: return W'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        entry_t e;
        if (bus.done) begin
            chk("busy_with_done", {31'b0, bus.busy}, '0);
            chk("done_width", {31'b0, prev_done}, '0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, bus.hi, e.r.hi);
                chk({e.name, "_lo"}, bus.lo, e.r.lo);
                chk({e.name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.r.dbz});
                chk({e.name, "_latency"}, W'(cyc), W'(e.due));
            end
            done_seen++;
        end
        prev_done = bus.done;
    end

    // Called at a negedge: presents one start and leaves the bus at the next negedge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input res_t r, input string nm);
        entry_t e;
        bus.start = 1'b1;
        bus.op    = op;
        bus.opA   = a;
        bus.opB   = b;
        e.r    = r;
        e.due  = cyc + W + 2;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.opA   = W'($urandom);
        bus.opB   = W'($urandom);
    endtask

    // Waits (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(input string nm, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", nm);
        end
    endtask

    initial begin
        int   bc;
        int   d0;
        res_t r;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        cyc       = 0;
        n_vec     = 0;
        n_err     = 0;
        done_seen = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.opA   = '0;
        bus.opB   = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", bus.hi, '0);
        chk("rst_lo", bus.lo, '0);
        chk("rst_busy", {31'b0, bus.busy}, '0);
        chk("rst_done", {31'b0, bus.done}, '0);
        chk("rst_dbz", {31'b0, bus.div_by_zero}, '0);
        rst = 1'b0;
        @(negedge clk);

        r = '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0};
        issue(2'b00, '1, '1, r, "multu_max");
        wait_done("multu_max", bc);
        chk("multu_max_busy_cycles", W'(bc), W'(W + 1));

        r = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0};
        issue(2'b01, 32'hFFFF_FFFD, 32'd7, r, "mult_neg3x7");
        wait_done("mult_neg3x7", bc);

        r = '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0};
        issue(2'b11, 32'hFFFF_FFF9, 32'd2, r, "div_neg7by2");
        wait_done("div_neg7by2", bc);

        r = '{hi: 32'h0, lo: 32'h8000_0000, dbz: 1'b0};
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, r, "div_min_by_m1");
        wait_done("div_min_by_m1", bc);

        r = '{hi: 32'h64, lo: 32'hFFFF_FFFF, dbz: 1'b1};
        issue(2'b10, 32'd100, 32'd0, r, "divu_by0");
        wait_done("divu_by0", bc);

        r = '{hi: 32'h0, lo: 32'd15, dbz: 1'b0};
        issue(2'b00, 32'd3, 32'd5, r, "multu_3x5");
        wait_done("multu_3x5", bc);

        // Start while busy must be dropped; then a back-to-back start in the done cycle.
        r = '{hi: 32'h0, lo: 32'd42, dbz: 1'b0};
        issue(2'b00, 32'd6, 32'd7, r, "multu_6x7");
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.opA   = 32'd100;
        bus.opB   = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("multu_6x7", bc);
        r = '{hi: 32'd1, lo: 32'd2, dbz: 1'b0};
        issue(2'b10, 32'd9, 32'd4, r, "divu_9by4_b2b");
        wait_done("divu_9by4_b2b", bc);

        // Load HI/LO with 0x1234/0x5678, then abort a MULT with reset.
        r = '{hi: 32'h1234, lo: 32'h5678, dbz: 1'b0};
        issue(2'b10, 32'h0ACF_1234, 32'h2000, r, "divu_preload");
        wait_done("divu_preload", bc);
        r = '{hi: 32'h0, lo: 32'd25, dbz: 1'b0};
        issue(2'b01, 32'd5, 32'd5, r, "mult_abort");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_hi", bus.hi, '0);
        chk("abort_lo", bus.lo, '0);
        chk("abort_busy", {31'b0, bus.busy}, '0);
        chk("abort_done", {31'b0, bus.done}, '0);
        d0 = done_seen;
        repeat (60) @(negedge clk);
        chk("abort_no_done", W'(done_seen), W'(d0));

        // Randomized ops, each issued in the done cycle of the previous one.
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom);
            a  = pick();
            b  = pick();
            r  = model(op, a, b);
            issue(op, a, b, r, $sformatf("rand%0d_op%0d", i, op));
            wait_done("rand", bc);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", W'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
